// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator with delayed sync/blank and line/vblank pulses
module vga_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int SYNC_DELAY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [9:0] line_cmp,
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       vblank_pulse,
  output logic       line_irq,
  output logic [7:0] frame_cnt
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(HT - 1);
  localparam logic [9:0] V_LAST   = 10'(VT - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  // Idle (reset) value of the {hsync, vsync, blank} bundle
  localparam logic [2:0] SYNC_IDLE = {~HS_ON, ~VS_ON, 1'b1};

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       h_wrap, v_wrap;
  logic       irq_set, vb_set;
  logic       line_irq_q, vblank_q;
  logic       active_raw;
  logic [2:0] sync_raw;

  // Next-state for the raster counters and the frame counter
  always_comb begin
    h_wrap      = (h_cnt_q == H_LAST);
    v_wrap      = (v_cnt_q == V_LAST);
    h_cnt_d     = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (h_wrap) begin
      if (v_wrap) begin
        v_cnt_d     = 10'd0;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end
    // A pulse is armed on the edge that moves the counters onto a line start
    irq_set = h_wrap && (v_cnt_d == line_cmp);
    vb_set  = h_wrap && (v_cnt_d == V_ACT);
  end

  // Raster counters advance only on enabled clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q     <= 10'd0;
      v_cnt_q     <= 10'd0;
      frame_cnt_q <= 8'd0;
    end else if (en) begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Pulse flags hold through disabled clocks so the pulse lands on one enabled clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_irq_q <= 1'b0;
      vblank_q   <= 1'b0;
    end else if (en) begin
      line_irq_q <= irq_set;
      vblank_q   <= vb_set;
    end
  end

  assign line_irq     = line_irq_q & en;
  assign vblank_pulse = vblank_q & en;

  // Undelayed raster decode straight from the counters
  always_comb begin
    active_raw  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    sync_raw[2] = ((h_cnt_q >= HS_START) && (h_cnt_q <= HS_END)) ? HS_ON : ~HS_ON;
    sync_raw[1] = ((v_cnt_q >= VS_START) && (v_cnt_q <= VS_END)) ? VS_ON : ~VS_ON;
    sync_raw[0] = ~active_raw;
  end

  assign posx      = h_cnt_q;
  assign posy      = (v_cnt_q < V_ACT) ? v_cnt_q[8:0] : 9'd0;
  assign active    = active_raw;
  assign frame_cnt = frame_cnt_q;

  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      // Pass-through; still forced idle during reset since counters read (0,0) = active
      assign {hsync, vsync, blank} = rst ? SYNC_IDLE : sync_raw;
    end else begin : g_dly
      logic [2:0] pipe_q [SYNC_DELAY];

      // Delay line for sync/blank, advancing only on enabled clocks
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_DELAY; i++) pipe_q[i] <= SYNC_IDLE;
        end else if (en) begin
          pipe_q[0] <= sync_raw;
          for (int i = 1; i < SYNC_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign {hsync, vsync, blank} = pipe_q[SYNC_DELAY-1];
    end
  endgenerate

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16; parameter H_SYNC, default 96; parameter H_BP, default 48; horizontal porch and sync widths in clocks.
REQ-003 Parameter V_ACTIVE, default 480; parameter V_FP, default 10; parameter V_SYNC, default 2; parameter V_BP, default 33; vertical widths in lines.
REQ-004 Parameter HS_POL, default 0; parameter VS_POL, default 0; sync active level.
REQ-005 Parameter SYNC_DELAY, default 2, range 0..7, pipeline delay applied to hsync/vsync/blank to match downstream fetch latency.
REQ-006 clk  input  1  pixel clock, all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 en  input  1  count enable; counters advance only when 1.
REQ-009 line_cmp  input  10  line number that raises line_irq.
REQ-010 posx  output  10  current horizontal count, undelayed.
REQ-011 posy  output  9  current vertical count while v_cnt < V_ACTIVE, else 0; undelayed.
REQ-012 active  output  1  high when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE; undelayed.
REQ-013 hsync, vsync  output  1 each  sync outputs, delayed SYNC_DELAY clocks.
REQ-014 blank  output  1  inverse of active, delayed SYNC_DELAY clocks.
REQ-015 vblank_pulse  output  1  one-clock pulse at start of vertical blanking.
REQ-016 line_irq  output  1  one-clock pulse at start of line line_cmp.
REQ-017 frame_cnt  output  8  completed-frame counter.

Function
REQ-018 h_cnt (10 bit) SHALL count 0..HT-1, HT = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default), wrapping to 0.
REQ-019 v_cnt (10 bit) SHALL increment once per h_cnt wrap; range 0..VT-1, VT = V_ACTIVE+V_FP+V_SYNC+V_BP (525 default), wrapping to 0.
REQ-020 When en=0, h_cnt, v_cnt, frame_cnt and the delay pipe SHALL hold; vblank_pulse and line_irq SHALL be 0.
REQ-021 Undelayed hsync SHALL be at HS_POL for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751 default), else at ~HS_POL.
REQ-022 Undelayed vsync SHALL be at VS_POL for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491 default), else at ~VS_POL.
REQ-023 hsync, vsync and blank SHALL equal their undelayed values from SYNC_DELAY enabled clocks earlier; SYNC_DELAY=0 SHALL be a combinational pass-through.
REQ-024 posx, posy and active SHALL be driven from the counter registers with zero latency.
REQ-025 vblank_pulse SHALL be registered high for one enabled clock when the counters enter h_cnt=0, v_cnt=V_ACTIVE.
REQ-026 line_irq SHALL be registered high for one enabled clock when the counters enter h_cnt=0, v_cnt=line_cmp.
REQ-027 line_irq SHALL never fire when line_cmp >= VT.
REQ-028 line_cmp SHALL be sampled every clock, so a change takes effect at the next line start.
REQ-029 frame_cnt SHALL increment modulo 256 when v_cnt wraps from VT-1 to 0, in the same clock as that wrap.
REQ-030 line_cmp = V_ACTIVE SHALL make line_irq and vblank_pulse fire in the same clock.

Reset
REQ-031 While rst=1, h_cnt, v_cnt and frame_cnt SHALL be 0; vblank_pulse and line_irq SHALL be 0.
REQ-032 While rst=1, hsync SHALL be ~HS_POL, vsync SHALL be ~VS_POL, and blank SHALL be 1, including every delay-pipe stage.
REQ-033 Reset asserted mid-line or mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-034 After rst deasserts, the first enabled clock edge SHALL advance h_cnt to 1.

Verification
REQ-035 Scenario: defaults, en=1, run 2 frames -> hsync low for 96 clocks every 800; vsync low for 2 lines every 525; frame_cnt=2 after 840000 clocks.
REQ-036 Scenario: SYNC_DELAY=2 -> blank falls 2 clocks after active rises at h_cnt=0, v_cnt=0; hsync falls 2 clocks after posx=656.
REQ-037 Scenario: line_cmp=100 -> line_irq pulses exactly once per frame, in the clock where posx=0 and posy=100; line_cmp=600 -> no pulse.
REQ-038 Scenario: en=0 for 50 clocks at posx=300 -> posx stays 300, no pulses; resumes at 301.
REQ-039 Scenario: rst pulsed asynchronously at v_cnt=200, h_cnt=400 -> posx=0, posy=0, hsync=1, vsync=1, blank=1, frame_cnt=0 before the next clock edge.
REQ-040 Scenario: line_cmp=480 -> line_irq and vblank_pulse are both high in the same clock, with posy=0 and active=0.
